// File: rtl/arch_map_table.sv
`default_nettype none
// ============================================================================
// Module   : arch_map_table
// Brief    : Committed architectural-to-physical register map; releases the
//            superseded physical register of each retiring destination.
// Revision : 1.0 - initial release
// ============================================================================
module arch_map_table #(
   parameter int          SIZE_ARCH         = 32,
   parameter int          SIZE_PHYSICAL     = 64,
   parameter int          SIZE_ARCH_LOG     = $clog2(SIZE_ARCH),
   parameter int          SIZE_PHYSICAL_LOG = $clog2(SIZE_PHYSICAL),
   parameter logic [31:0] RETIRE_CNT_RESET  = 32'd0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   commitValid0_i,
   input  logic                                   commitValid1_i,
   input  logic                                   commitValid2_i,
   input  logic                                   commitValid3_i,
   input  logic [SIZE_ARCH_LOG-1:0]               commitLogDest0_i,
   input  logic [SIZE_ARCH_LOG-1:0]               commitLogDest1_i,
   input  logic [SIZE_ARCH_LOG-1:0]               commitLogDest2_i,
   input  logic [SIZE_ARCH_LOG-1:0]               commitLogDest3_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0]           commitPhyDest0_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0]           commitPhyDest1_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0]           commitPhyDest2_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0]           commitPhyDest3_i,
   output logic                                   freeValid0_o,
   output logic                                   freeValid1_o,
   output logic                                   freeValid2_o,
   output logic                                   freeValid3_o,
   output logic [SIZE_PHYSICAL_LOG-1:0]           freeReg0_o,
   output logic [SIZE_PHYSICAL_LOG-1:0]           freeReg1_o,
   output logic [SIZE_PHYSICAL_LOG-1:0]           freeReg2_o,
   output logic [SIZE_PHYSICAL_LOG-1:0]           freeReg3_o,
   output logic [SIZE_ARCH*SIZE_PHYSICAL_LOG-1:0] recoverMap_o,
   output logic [31:0]                            retireCnt_o
);

   localparam int c_SLOTS = 4;

   logic [SIZE_PHYSICAL_LOG-1:0] r_table    [SIZE_ARCH];
   logic [c_SLOTS-1:0]           r_freeValid;
   logic [SIZE_PHYSICAL_LOG-1:0] r_freeReg  [c_SLOTS];
   logic [31:0]                  r_retireCnt;

   logic [c_SLOTS-1:0]           w_valid;
   logic [SIZE_ARCH_LOG-1:0]     w_logDest  [c_SLOTS];
   logic [SIZE_PHYSICAL_LOG-1:0] w_phyDest  [c_SLOTS];
   logic [SIZE_PHYSICAL_LOG-1:0] w_oldMap   [c_SLOTS];
   logic [31:0]                  w_commitCnt;

   assign w_valid      = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
   assign w_logDest[0] = commitLogDest0_i;
   assign w_logDest[1] = commitLogDest1_i;
   assign w_logDest[2] = commitLogDest2_i;
   assign w_logDest[3] = commitLogDest3_i;
   assign w_phyDest[0] = commitPhyDest0_i;
   assign w_phyDest[1] = commitPhyDest1_i;
   assign w_phyDest[2] = commitPhyDest2_i;
   assign w_phyDest[3] = commitPhyDest3_i;

   // An older slot in the same group writing the same register supersedes the
   // table; scanning oldest-to-youngest leaves the youngest such slot in place.
   always_comb begin
      for (int n = 0; n < c_SLOTS; n++) begin
         w_oldMap[n] = r_table[w_logDest[n]];
         for (int j = 0; j < n; j++) begin
            if (w_valid[j] && (w_logDest[j] == w_logDest[n])) begin
               w_oldMap[n] = w_phyDest[j];
            end
         end
      end
   end

   assign w_commitCnt = 32'(w_valid[0]) + 32'(w_valid[1]) + 32'(w_valid[2]) + 32'(w_valid[3]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SIZE_ARCH; i++) begin
            r_table[i] <= SIZE_PHYSICAL_LOG'(i);
         end
         for (int n = 0; n < c_SLOTS; n++) begin
            r_freeReg[n] <= '0;
         end
         r_freeValid <= '0;
         r_retireCnt <= RETIRE_CNT_RESET;
      end else begin
         // Later non-blocking writes override earlier ones: youngest slot wins.
         for (int n = 0; n < c_SLOTS; n++) begin
            if (w_valid[n]) begin
               r_table[w_logDest[n]] <= w_phyDest[n];
            end
            r_freeReg[n] <= w_valid[n] ? w_oldMap[n] : '0;
         end
         r_freeValid <= w_valid;
         r_retireCnt <= r_retireCnt + w_commitCnt;
      end
   end

   generate
      for (genvar i = 0; i < SIZE_ARCH; i++) begin : g_recoverMap
         assign recoverMap_o[i*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] = r_table[i];
      end
   endgenerate

   assign freeValid0_o = r_freeValid[0];
   assign freeValid1_o = r_freeValid[1];
   assign freeValid2_o = r_freeValid[2];
   assign freeValid3_o = r_freeValid[3];
   assign freeReg0_o   = r_freeReg[0];
   assign freeReg1_o   = r_freeReg[1];
   assign freeReg2_o   = r_freeReg[2];
   assign freeReg3_o   = r_freeReg[3];
   assign retireCnt_o  = r_retireCnt;

endmodule
`default_nettype wire

// File: tb/tb_arch_map_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_arch_map_table
// Brief    : Directed self-checking bench for arch_map_table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arch_map_table;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  cv, cvW;
   logic [4:0]  cl [4];
   logic [4:0]  clW [4];
   logic [5:0]  cp [4];
   logic [5:0]  cpW [4];
   logic        fv0, fv1, fv2, fv3, fvW0, fvW1, fvW2, fvW3;
   logic [5:0]  fr0, fr1, fr2, fr3, frW0, frW1, frW2, frW3;
   logic [191:0] recoverMap, recoverMapW, identMap;
   logic [31:0] retireCnt, retireCntW;
   logic [3:0]  fv;

   int chkCnt = 0;
   int errCnt = 0;

   always #5 clk = ~clk;
   assign fv = {fv3, fv2, fv1, fv0};

   arch_map_table dut (
      .clk(clk), .reset(reset),
      .commitValid0_i(cv[0]), .commitValid1_i(cv[1]), .commitValid2_i(cv[2]), .commitValid3_i(cv[3]),
      .commitLogDest0_i(cl[0]), .commitLogDest1_i(cl[1]), .commitLogDest2_i(cl[2]), .commitLogDest3_i(cl[3]),
      .commitPhyDest0_i(cp[0]), .commitPhyDest1_i(cp[1]), .commitPhyDest2_i(cp[2]), .commitPhyDest3_i(cp[3]),
      .freeValid0_o(fv0), .freeValid1_o(fv1), .freeValid2_o(fv2), .freeValid3_o(fv3),
      .freeReg0_o(fr0), .freeReg1_o(fr1), .freeReg2_o(fr2), .freeReg3_o(fr3),
      .recoverMap_o(recoverMap), .retireCnt_o(retireCnt)
   );

   // Second instance starts its counter near the top to exercise the wrap.
   arch_map_table #(.RETIRE_CNT_RESET(32'hFFFF_FFFE)) dutWrap (
      .clk(clk), .reset(reset),
      .commitValid0_i(cvW[0]), .commitValid1_i(cvW[1]), .commitValid2_i(cvW[2]), .commitValid3_i(cvW[3]),
      .commitLogDest0_i(clW[0]), .commitLogDest1_i(clW[1]), .commitLogDest2_i(clW[2]), .commitLogDest3_i(clW[3]),
      .commitPhyDest0_i(cpW[0]), .commitPhyDest1_i(cpW[1]), .commitPhyDest2_i(cpW[2]), .commitPhyDest3_i(cpW[3]),
      .freeValid0_o(fvW0), .freeValid1_o(fvW1), .freeValid2_o(fvW2), .freeValid3_o(fvW3),
      .freeReg0_o(frW0), .freeReg1_o(frW1), .freeReg2_o(frW2), .freeReg3_o(frW3),
      .recoverMap_o(recoverMapW), .retireCnt_o(retireCntW)
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] entry(input int i);
      return recoverMap[i*6 +: 6];
   endfunction

   task automatic clearIn();
      cv = '0;
      cvW = '0;
      for (int n = 0; n < 4; n++) begin
         cl[n] = '0; cp[n] = '0; clW[n] = '0; cpW[n] = '0;
      end
   endtask

   task automatic setSlot(input int n, input logic [4:0] l, input logic [5:0] p);
      cv[n] = 1'b1; cl[n] = l; cp[n] = p;
   endtask

   // Commit whatever is on the inputs at the next edge, then clear them.
   task automatic step();
      @(posedge clk);
      #1;
      clearIn();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) identMap[i*6 +: 6] = 6'(i);
      clearIn();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("rstFreeValid", 64'(fv), 64'h0);
      checkVal("rstFreeReg0", 64'(fr0), 64'h0);
      checkVal("rstRetireCnt", 64'(retireCnt), 64'h0);
      checkVal("rstIdentity", 64'(recoverMap == identMap), 64'h1);
      @(negedge clk);
      reset = 1'b1;

      // Single commit
      setSlot(0, 5'd3, 6'd40);
      step();
      checkVal("singleFreeValid", 64'(fv), 64'b0001);
      checkVal("singleFreeReg0", 64'(fr0), 64'd3);
      checkVal("singleEntry3", 64'(entry(3)), 64'd40);
      checkVal("singleCnt", 64'(retireCnt), 64'd1);

      // Intra-group collision
      setSlot(0, 5'd7, 6'd33); setSlot(1, 5'd7, 6'd34); setSlot(2, 5'd7, 6'd35);
      step();
      checkVal("collFreeValid", 64'(fv), 64'b0111);
      checkVal("collFreeReg0", 64'(fr0), 64'd7);
      checkVal("collFreeReg1", 64'(fr1), 64'd33);
      checkVal("collFreeReg2", 64'(fr2), 64'd34);
      checkVal("collFreeReg3", 64'(fr3), 64'd0);
      checkVal("collEntry7", 64'(entry(7)), 64'd35);
      checkVal("collCnt", 64'(retireCnt), 64'd4);

      // Sparse pattern; invalid slots carry junk that must be ignored
      cl[0] = 5'd3; cp[0] = 6'd60; cl[2] = 5'd3; cp[2] = 6'd61;
      setSlot(1, 5'd5, 6'd50); setSlot(3, 5'd6, 6'd51);
      step();
      checkVal("sparseFreeValid", 64'(fv), 64'b1010);
      checkVal("sparseFreeReg1", 64'(fr1), 64'd5);
      checkVal("sparseFreeReg3", 64'(fr3), 64'd6);
      checkVal("sparseFreeReg0", 64'(fr0), 64'd0);
      checkVal("sparseFreeReg2", 64'(fr2), 64'd0);
      checkVal("sparseCnt", 64'(retireCnt), 64'd6);
      checkVal("sparseEntry5", 64'(entry(5)), 64'd50);
      checkVal("sparseEntry6", 64'(entry(6)), 64'd51);
      checkVal("sparseEntry3", 64'(entry(3)), 64'd40);

      // Back-to-back commits to the same register
      setSlot(0, 5'd2, 6'd45);
      step();
      checkVal("b2bFreeRegA", 64'(fr0), 64'd2);
      setSlot(0, 5'd2, 6'd46);
      step();
      checkVal("b2bFreeRegB", 64'(fr0), 64'd45);
      checkVal("b2bEntry2", 64'(entry(2)), 64'd46);
      checkVal("b2bCnt", 64'(retireCnt), 64'd8);

      // Idle cycle
      step();
      checkVal("idleFreeValid", 64'(fv), 64'b0000);
      checkVal("idleFreeReg0", 64'(fr0), 64'd0);
      checkVal("idleCnt", 64'(retireCnt), 64'd8);

      // Non-adjacent collision (slot 3 sees slot 1) plus a self-mapping commit
      setSlot(0, 5'd9, 6'd9); setSlot(1, 5'd10, 6'd20); setSlot(3, 5'd10, 6'd21);
      step();
      checkVal("gapFreeValid", 64'(fv), 64'b1011);
      checkVal("selfFreeReg0", 64'(fr0), 64'd9);
      checkVal("gapFreeReg1", 64'(fr1), 64'd10);
      checkVal("gapFreeReg3", 64'(fr3), 64'd20);
      checkVal("gapEntry10", 64'(entry(10)), 64'd21);
      checkVal("selfEntry9", 64'(entry(9)), 64'd9);
      checkVal("gapCnt", 64'(retireCnt), 64'd11);

      // Asynchronous reset between edges, with a commit pending on the inputs
      setSlot(0, 5'd3, 6'd41);
      step();
      checkVal("preRstFreeValid", 64'(fv), 64'b0001);
      checkVal("preRstFreeReg0", 64'(fr0), 64'd40);
      setSlot(0, 5'd4, 6'd55);
      #2;
      reset = 1'b0;
      #1;
      checkVal("asyncFreeValid", 64'(fv), 64'h0);
      checkVal("asyncFreeReg0", 64'(fr0), 64'h0);
      checkVal("asyncCnt", 64'(retireCnt), 64'h0);
      checkVal("asyncIdentity", 64'(recoverMap == identMap), 64'h1);
      @(posedge clk);
      #1;
      checkVal("heldEntry4", 64'(entry(4)), 64'd4);
      clearIn();
      @(negedge clk);
      reset = 1'b1;
      setSlot(0, 5'd3, 6'd42);
      step();
      checkVal("postRstFreeReg0", 64'(fr0), 64'd3);
      checkVal("postRstEntry3", 64'(entry(3)), 64'd42);
      checkVal("postRstCnt", 64'(retireCnt), 64'd1);

      // Counter wrap on the preloaded instance
      checkVal("wrapPreload", 64'(retireCntW), 64'hFFFF_FFFE);
      cvW = 4'b1111;
      clW[0] = 5'd1; clW[1] = 5'd2; clW[2] = 5'd3; clW[3] = 5'd4;
      cpW[0] = 6'd32; cpW[1] = 6'd33; cpW[2] = 6'd34; cpW[3] = 6'd35;
      step();
      checkVal("wrapCnt", 64'(retireCntW), 64'h0000_0002);
      checkVal("wrapFreeRegs", 64'({frW3, frW2, frW1, frW0}), 64'({6'd4, 6'd3, 6'd2, 6'd1}));
      checkVal("wrapFreeValid", 64'({fvW3, fvW2, fvW1, fvW0}), 64'b1111);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arch_map_table.md
ARCH_MAP_TABLE -- requirements
Module: arch_map_table

Interface
REQ-001 SHALL have parameter SIZE_ARCH, default 32: number of architectural registers, with log2 SIZE_ARCH_LOG = 5.
REQ-002 SHALL have parameter SIZE_PHYSICAL, default 64: number of physical registers, with log2 SIZE_PHYSICAL_LOG = 6.
REQ-003 SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset; 0 resets the block.
REQ-005 SHALL have ports commitValidN_i (N=0..3), input, 1 each: retiring instruction in slot N writes a destination.
REQ-006 SHALL have ports commitLogDestN_i, input, SIZE_ARCH_LOG each: architectural destination of slot N.
REQ-007 SHALL have ports commitPhyDestN_i, input, SIZE_PHYSICAL_LOG each: physical destination of slot N.
REQ-008 SHALL have ports freeValidN_o, output, 1 each: the old mapping of slot N is released (drives SpecFreeList commitValidN_i).
REQ-009 SHALL have ports freeRegN_o, output, SIZE_PHYSICAL_LOG each: physical register released by slot N (drives SpecFreeList commitRegN_i).
REQ-010 SHALL have port recoverMap_o, output, SIZE_ARCH*SIZE_PHYSICAL_LOG: committed map; entry i occupies bits [i*6+5 : i*6].
REQ-011 SHALL have port retireCnt_o, output, 32: running count of destination-writing retirements.

Function
REQ-012 SHALL hold a table of SIZE_ARCH entries, each SIZE_PHYSICAL_LOG wide, giving the committed architectural-to-physical map.
REQ-013 SHALL treat slots as program-ordered, slot 0 oldest; valid bits need not be contiguous, so the pattern 4'b1010 is legal.
REQ-014 SHALL compute the old mapping of valid slot N as follows.
  - If one or more older valid slots (j<N) in the same cycle carry the same commitLogDest, use commitPhyDest of the youngest such j.
  - Otherwise use the table entry for commitLogDestN_i as held before the clock edge.
REQ-015 SHALL, at each rising edge, write commitPhyDestN_i into the entry for every valid slot; when slots collide on one entry, the youngest valid slot wins.
REQ-016 SHALL register freeValidN_o <= commitValidN_i and freeRegN_o <= the old mapping of slot N, giving latency 1 cycle.
REQ-017 SHALL drive freeRegN_o to 0 in any cycle where freeValidN_o=0.
REQ-018 SHALL drive recoverMap_o directly from the table register, so it reflects all commits up to and including the previous edge.
REQ-019 SHALL increment retireCnt_o by popcount(commitValid0_i..3_i) per cycle (range 0..4), wrapping modulo 2^32.
REQ-020 SHALL have no stall input: commit is never back-pressured, because SpecFreeList accepts up to 4 pushes per cycle unconditionally.
REQ-021 SHALL perform no range checking: commitPhyDestN_i >= SIZE_PHYSICAL is undefined input.
REQ-022 SHALL release a slot whose commitPhyDest equals its old mapping exactly as any other slot; no special case applies.
REQ-023 SHALL not reset the table on pipeline recovery; SpecFreeList/rename consume recoverMap_o while commits in that cycle proceed normally.

Reset
REQ-024 SHALL, on reset=0, asynchronously set table entry i = i for all i, all freeValidN_o = 0, all freeRegN_o = 0 and retireCnt_o = 0.
REQ-025 SHALL, with this identity table, leave physical registers SIZE_ARCH..SIZE_PHYSICAL-1 as the free pool, matching SpecFreeList reset contents.
REQ-026 SHALL let reset asserted mid-operation discard all same-cycle commits, with outputs reaching reset values immediately rather than at the next edge.
REQ-027 SHALL resume normal operation at the first rising edge after reset deasserts.

Verification
REQ-028 SHALL cover single commit: after reset, slot0 valid, log 3, phy 40 -> next cycle freeValid0_o=1, freeReg0_o=3; recoverMap_o entry 3 = 40.
REQ-029 SHALL cover an intra-group collision.
  - Stimulus: slots 0..2 valid, all log 7, phys 33/34/35.
  - Response: freeReg0_o=7, freeReg1_o=33, freeReg2_o=34; entry 7 = 35.
REQ-030 SHALL cover a sparse pattern.
  - Stimulus: valid 4'b1010, slot1 log 5 phy 50, slot3 log 6 phy 51.
  - Response: freeValid = 4'b1010, freeReg1_o=5, freeReg3_o=6, freeReg0_o=freeReg2_o=0; retireCnt_o += 2.
REQ-031 SHALL cover back-to-back commits: cycle A log 2 phy 45, cycle B log 2 phy 46 -> cycle B+1 freeReg0_o=45; entry 2 = 46.
REQ-032 SHALL cover async reset.
  - Stimulus: assert reset between edges while outputs are nonzero.
  - Response: outputs clear without waiting for an edge; recoverMap_o is identity; the next commit to log 3 releases 3.
REQ-033 SHALL cover counter wrap: preload retireCnt_o to 0xFFFFFFFE, commit 4 valid slots -> retireCnt_o=0x00000002.
